// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, funct codes, ALU ops, reg_dst codes and
// the bit layout of the 16-bit control bundle carried from ID to EX.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // ALU_ADD is zero so an all-zero bundle is a harmless NOP
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_RA = 2'd2;

    localparam int CTRL_W         = 16;
    localparam int CB_SHAMT_VAR   = 0;
    localparam int CB_LINK        = 1;
    localparam int CB_JUMP        = 2;
    localparam int CB_BRANCH_NE   = 3;
    localparam int CB_BRANCH      = 4;
    localparam int CB_REG_WRITE   = 5;
    localparam int CB_ALU_SRC_IMM = 6;
    localparam int CB_MEM_TO_REG  = 7;
    localparam int CB_MEM_READ    = 8;
    localparam int CB_MEM_WRITE   = 9;
    localparam int CB_REG_DST     = 10;
    localparam int CB_ALU_OP      = 12;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decode: control bundle, resolved destination,
// split instruction fields and which source registers the instruction really reads.
module ctrl_decode
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       instr,
    output logic [CTRL_W-1:0] ctrl,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] wreg,
    output logic [15:0]       imm,
    output logic [4:0]        shamt,
    output logic              use_rs,
    output logic              use_rt,
    output logic              known
);

    logic [5:0]        op, fn;
    logic [REG_AW-1:0] rd;

    assign op    = instr[31:26];
    assign fn    = instr[5:0];
    assign rs    = REG_AW'(instr[25:21]);
    assign rt    = REG_AW'(instr[20:16]);
    assign rd    = REG_AW'(instr[15:11]);
    assign imm   = instr[15:0];
    assign shamt = instr[10:6];

    always_comb begin
        ctrl   = '0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        known  = 1'b1;
        wreg   = '0;
        case (op)
            OP_RTYPE: begin
                ctrl[CB_REG_DST +: 2] = RDST_RD;
                ctrl[CB_REG_WRITE]    = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
                case (fn)
                    FN_ADD, FN_ADDU: ctrl[CB_ALU_OP +: 4] = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl[CB_ALU_OP +: 4] = ALU_SUB;
                    FN_AND:          ctrl[CB_ALU_OP +: 4] = ALU_AND;
                    FN_OR:           ctrl[CB_ALU_OP +: 4] = ALU_OR;
                    FN_XOR:          ctrl[CB_ALU_OP +: 4] = ALU_XOR;
                    FN_NOR:          ctrl[CB_ALU_OP +: 4] = ALU_NOR;
                    FN_SLT:          ctrl[CB_ALU_OP +: 4] = ALU_SLT;
                    // constant shifts read only rt; variable shifts also read rs
                    FN_SLL: begin ctrl[CB_ALU_OP +: 4] = ALU_SLL; use_rs = 1'b0; end
                    FN_SRL: begin ctrl[CB_ALU_OP +: 4] = ALU_SRL; use_rs = 1'b0; end
                    FN_SRA: begin ctrl[CB_ALU_OP +: 4] = ALU_SRA; use_rs = 1'b0; end
                    FN_SLLV: begin ctrl[CB_ALU_OP +: 4] = ALU_SLL; ctrl[CB_SHAMT_VAR] = 1'b1; end
                    FN_SRLV: begin ctrl[CB_ALU_OP +: 4] = ALU_SRL; ctrl[CB_SHAMT_VAR] = 1'b1; end
                    FN_SRAV: begin ctrl[CB_ALU_OP +: 4] = ALU_SRA; ctrl[CB_SHAMT_VAR] = 1'b1; end
                    default: begin
                        ctrl   = '0;
                        use_rs = 1'b0;
                        use_rt = 1'b0;
                        known  = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl[CB_ALU_SRC_IMM] = 1'b1;
                ctrl[CB_REG_WRITE]   = 1'b1;
                use_rs = 1'b1;
                if (op == OP_ANDI)      ctrl[CB_ALU_OP +: 4] = ALU_AND;
                else if (op == OP_ORI)  ctrl[CB_ALU_OP +: 4] = ALU_OR;
                else if (op == OP_XORI) ctrl[CB_ALU_OP +: 4] = ALU_XOR;
                else                    ctrl[CB_ALU_OP +: 4] = ALU_ADD;
            end
            OP_LW: begin
                ctrl[CB_ALU_SRC_IMM] = 1'b1;
                ctrl[CB_MEM_READ]    = 1'b1;
                ctrl[CB_MEM_TO_REG]  = 1'b1;
                ctrl[CB_REG_WRITE]   = 1'b1;
                use_rs = 1'b1;
            end
            OP_SW: begin
                ctrl[CB_ALU_SRC_IMM] = 1'b1;
                ctrl[CB_MEM_WRITE]   = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl[CB_ALU_OP +: 4] = ALU_SUB;
                ctrl[CB_BRANCH]      = 1'b1;
                ctrl[CB_BRANCH_NE]   = (op == OP_BNE);
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_J: ctrl[CB_JUMP] = 1'b1;
            OP_JAL: begin
                ctrl[CB_JUMP]         = 1'b1;
                ctrl[CB_LINK]         = 1'b1;
                ctrl[CB_REG_WRITE]    = 1'b1;
                ctrl[CB_REG_DST +: 2] = RDST_RA;
            end
            default: known = 1'b0;
        endcase

        case (ctrl[CB_REG_DST +: 2])
            RDST_RD: wreg = rd;
            RDST_RA: wreg = REG_AW'(5'd31);
            default: wreg = rt;
        endcase
        // writes to $0 are architecturally discarded
        if (wreg == '0) ctrl[CB_REG_WRITE] = 1'b0;
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// ID stage control: decode into the ID/EX register, load-use stall, branch flush and
// halt drain. Define CTRL_ILLEGAL_TRAP_EN to trap unknown encodings like a halt.
module id_ctrl_stage
    import mips_pkg::*;
#(
    parameter int          REG_AW       = 5,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [15:0]       out_ctrl,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_wreg,
    output logic [15:0]       out_imm,
    output logic [4:0]        out_shamt,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [REG_AW-1:0] rs_q, rt_q, wreg_q;
    logic [15:0]       imm_q;
    logic [4:0]        shamt_q;

    logic [CTRL_W-1:0] dec_ctrl;
    logic [REG_AW-1:0] dec_rs, dec_rt, dec_wreg;
    logic [15:0]       dec_imm;
    logic [4:0]        dec_shamt;
    logic              dec_use_rs, dec_use_rt, dec_known;

    logic hazard, is_halt, trap, accept, stop, load;

    ctrl_decode #(.REG_AW(REG_AW)) u_dec (
        .instr  (in_instr),
        .ctrl   (dec_ctrl),
        .rs     (dec_rs),
        .rt     (dec_rt),
        .wreg   (dec_wreg),
        .imm    (dec_imm),
        .shamt  (dec_shamt),
        .use_rs (dec_use_rs),
        .use_rt (dec_use_rt),
        .known  (dec_known)
    );

    // Hazard looks only at in_instr, never in_valid, so in_ready stays off the valid path
    assign hazard = valid_q & ctrl_q[CB_MEM_READ] & (wreg_q != '0) &
                    ((dec_use_rs & (dec_rs == wreg_q)) | (dec_use_rt & (dec_rt == wreg_q)));
    assign is_halt = (in_instr == HALT_WORD);

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap = ~dec_known & ~is_halt;
`else
    logic unused_known;
    assign unused_known = dec_known;
    assign trap         = 1'b0;
`endif

    assign accept = in_valid & in_ready & ~flush;
    assign stop   = accept & (is_halt | trap);
    assign load   = accept & ~stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (stop) begin
                    state_d = S_DRAIN;
                    cnt_d   = 4'(DRAIN_CYCLES);
                end
            end
            S_DRAIN: begin
                // a flush here means the halt word was on the wrong path
                if (flush) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_HALTED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_RUN:    in_ready = flush | ~hazard;
            S_DRAIN:  in_ready = flush;
            S_HALTED: halted   = 1'b1;
            default:  in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            wreg_q  <= '0;
            imm_q   <= '0;
            shamt_q <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            ctrl_q  <= dec_ctrl;
            rs_q    <= dec_rs;
            rt_q    <= dec_rt;
            wreg_q  <= dec_wreg;
            imm_q   <= dec_imm;
            shamt_q <= dec_shamt;
        end else begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            wreg_q  <= '0;
            imm_q   <= '0;
            shamt_q <= '0;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               illegal_q <= 1'b0;
        else if (accept & trap)   illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign out_valid = valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_rs    = rs_q;
    assign out_rt    = rt_q;
    assign out_wreg  = wreg_q;
    assign out_imm   = imm_q;
    assign out_shamt = shamt_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: directed scenarios plus a randomized stream checked against
// a mnemonic-level reference model of decode and load-use stalling.
module tb_id_ctrl_stage;

    localparam int          DRAIN = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, in_ready, out_valid, halted, illegal;
    logic [31:0] in_instr;
    logic [15:0] out_ctrl, out_imm;
    logic [4:0]  out_rs, out_rt, out_wreg, out_shamt;

    int n_cmp = 0;
    int n_err = 0;

    int fns[15] = '{0, 2, 3, 4, 6, 7, 32, 33, 34, 35, 36, 37, 38, 39, 42};
    int ops[11] = '{2, 3, 4, 5, 8, 9, 12, 13, 14, 35, 43};

    typedef struct {
        logic [15:0] ctrl;
        logic [4:0]  wreg;
        bit          urs;
        bit          urt;
    } exp_t;

    id_ctrl_stage #(.REG_AW(5), .DRAIN_CYCLES(DRAIN), .HALT_WORD(HALT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ctrl(out_ctrl),
        .out_rs(out_rs), .out_rt(out_rt), .out_wreg(out_wreg), .out_imm(out_imm),
        .out_shamt(out_shamt), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] jtype(int op, int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    function automatic string mnem(logic [31:0] w);
        if (w[31:26] == 6'd0) begin
            case (w[5:0])
                6'd0: return "sll";   6'd2: return "srl";   6'd3: return "sra";
                6'd4: return "sllv";  6'd6: return "srlv";  6'd7: return "srav";
                6'd32: return "add";  6'd33: return "addu"; 6'd34: return "sub";
                6'd35: return "subu"; 6'd36: return "and";  6'd37: return "or";
                6'd38: return "xor";  6'd39: return "nor";  6'd42: return "slt";
                default: return "";
            endcase
        end
        case (w[31:26])
            6'd2: return "j";     6'd3: return "jal";   6'd4: return "beq";
            6'd5: return "bne";   6'd8: return "addi";  6'd9: return "addiu";
            6'd12: return "andi"; 6'd13: return "ori";  6'd14: return "xori";
            6'd35: return "lw";   6'd43: return "sw";
            default: return "";
        endcase
    endfunction

    // Reference: derive each control field from the instruction's meaning
    function automatic exp_t model(logic [31:0] w);
        exp_t  e;
        string m = mnem(w);
        bit r     = (w[31:26] == 6'd0) && (m != "");
        bit cshf  = (m == "sll") || (m == "srl") || (m == "sra");
        bit vshf  = (m == "sllv") || (m == "srlv") || (m == "srav");
        bit ialu  = (m == "addi") || (m == "addiu") || (m == "andi") || (m == "ori") || (m == "xori");
        bit br    = (m == "beq") || (m == "bne");
        int alu   = 0;
        int dst;
        bit rw;
        if (m == "sub" || m == "subu" || br)     alu = 1;
        else if (m == "and" || m == "andi")      alu = 2;
        else if (m == "or" || m == "ori")        alu = 3;
        else if (m == "xor" || m == "xori")      alu = 4;
        else if (m == "nor")                     alu = 5;
        else if (m == "slt")                     alu = 6;
        else if (m == "sll" || m == "sllv")      alu = 7;
        else if (m == "srl" || m == "srlv")      alu = 8;
        else if (m == "sra" || m == "srav")      alu = 9;
        dst = r ? 1 : (m == "jal") ? 2 : 0;
        e.wreg = (dst == 2) ? 5'd31 : (dst == 1) ? w[15:11] : w[20:16];
        rw = (r || ialu || m == "lw" || m == "jal") && (e.wreg != 5'd0);
        e.ctrl = {4'(alu), 2'(dst), m == "sw", m == "lw", m == "lw",
                  ialu || m == "lw" || m == "sw", rw, br, m == "bne",
                  m == "j" || m == "jal", m == "jal", vshf};
        e.urs = (r && !cshf) || ialu || m == "lw" || m == "sw" || br;
        e.urt = r || m == "sw" || br;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        int k = $urandom_range(0, 3);
        int a = $urandom_range(0, 3);
        int b = $urandom_range(0, 3);
        int c = $urandom_range(0, 3);
        if (k == 0) return itype(35, a, b, $urandom);
        if (k == 1) return rtype(a, b, c, $urandom_range(0, 31), fns[$urandom_range(0, 14)]);
        return itype(ops[$urandom_range(0, 10)], a, b, $urandom);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_instr = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = rtype(1, 2, 3, 0, 32);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if ({out_ctrl, out_wreg, out_rs, out_rt, out_imm, out_shamt} !== '0) begin n_err++; $display("FAIL reset_fields got %h want 0", {out_ctrl, out_wreg, out_rs, out_rt, out_imm, out_shamt}); end
        n_cmp++; if ({halted, illegal} !== 2'b00) begin n_err++; $display("FAIL reset_sticky got %b want 00", {halted, illegal}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        @(negedge clk);
        in_valid = 1'b1; in_instr = rtype(1, 2, 3, 0, 32);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b want 1", out_valid); end
        n_cmp++; if (out_ctrl !== 16'h0420) begin n_err++; $display("FAIL add_ctrl got %h want 0420", out_ctrl); end
        n_cmp++; if ({out_wreg, out_rs, out_rt} !== {5'd3, 5'd1, 5'd2}) begin n_err++; $display("FAIL add_regs got %0d/%0d/%0d want 3/1/2", out_wreg, out_rs, out_rt); end
        in_valid = 1'b0;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        in_valid = 1'b1; in_instr = itype(35, 1, 5, 0);
        @(posedge clk); #1;
        n_cmp++; if (out_ctrl !== 16'h01E0 || out_wreg !== 5'd5) begin n_err++; $display("FAIL lw_decode got %h/%0d want 01e0/5", out_ctrl, out_wreg); end
        @(negedge clk);
        in_instr = rtype(5, 2, 6, 0, 32);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lu_stall_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== 16'h0) begin n_err++; $display("FAIL lu_bubble got %b/%h want 0/0000", out_valid, out_ctrl); end
        @(negedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lu_release_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || out_wreg !== 5'd6) begin n_err++; $display("FAIL lu_issue got %b/%0d want 1/6", out_valid, out_wreg); end
        @(negedge clk);
        in_instr = itype(35, 1, 5, 0);
        @(negedge clk);
        in_instr = jtype(2, {5'd5, 5'd5, 16'd0});
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lu_jump_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || out_ctrl !== 16'h0004) begin n_err++; $display("FAIL lu_jump_issue got %b/%h want 1/0004", out_valid, out_ctrl); end
        in_valid = 1'b0;
    endtask

    task automatic test_jal();
        @(negedge clk);
        in_valid = 1'b1; in_instr = jtype(3, 26'h40);
        @(posedge clk); #1;
        n_cmp++; if (out_ctrl !== 16'h0826 || out_wreg !== 5'd31) begin n_err++; $display("FAIL jal got %h/%0d want 0826/31", out_ctrl, out_wreg); end
        @(negedge clk);
        in_instr = itype(8, 1, 0, 7);
        @(posedge clk); #1;
        n_cmp++; if (out_ctrl !== 16'h0040 || out_wreg !== 5'd0 || out_imm !== 16'd7) begin n_err++; $display("FAIL addi_r0 got %h/%0d/%0d want 0040/0/7", out_ctrl, out_wreg, out_imm); end
        in_valid = 1'b0;
    endtask

    task automatic test_flush_stall();
        @(negedge clk);
        in_valid = 1'b1; in_instr = itype(35, 1, 5, 0);
        @(negedge clk);
        in_instr = rtype(5, 2, 6, 0, 32); flush = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fs_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fs_dropped got %b want 0", out_valid); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fs_after_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || out_wreg !== 5'd6) begin n_err++; $display("FAIL fs_after_issue got %b/%0d want 1/6", out_valid, out_wreg); end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        bit          pv = 0, pmr = 0, haz, rdy, take;
        logic [4:0]  pw = '0;
        logic [31:0] w;
        exp_t        e;
        logic [35:0] got_f, exp_f;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            w = rand_instr();
            in_instr = w;
            in_valid = ($urandom_range(0, 9) < 8);
            flush    = ($urandom_range(0, 9) == 0);
            e    = model(w);
            haz  = pv && pmr && (pw != 5'd0) &&
                   ((e.urs && w[25:21] == pw) || (e.urt && w[20:16] == pw));
            rdy  = flush || !haz;
            take = in_valid && rdy && !flush;
            #1;
            n_cmp++; if (in_ready !== rdy) begin n_err++; $display("FAIL rnd_ready i=%0d instr=%h got %b want %b", i, w, in_ready, rdy); end
            @(posedge clk); #1;
            got_f = {out_rs, out_rt, out_imm, out_shamt};
            exp_f = take ? {w[25:21], w[20:16], w[15:0], w[10:6]} : '0;
            n_cmp++; if (out_valid !== take) begin n_err++; $display("FAIL rnd_valid i=%0d got %b want %b", i, out_valid, take); end
            n_cmp++; if (out_ctrl !== (take ? e.ctrl : 16'h0)) begin n_err++; $display("FAIL rnd_ctrl i=%0d instr=%h got %h want %h", i, w, out_ctrl, take ? e.ctrl : 16'h0); end
            n_cmp++; if (out_wreg !== (take ? e.wreg : 5'd0)) begin n_err++; $display("FAIL rnd_wreg i=%0d got %0d want %0d", i, out_wreg, take ? e.wreg : 5'd0); end
            n_cmp++; if (got_f !== exp_f) begin n_err++; $display("FAIL rnd_fields i=%0d got %h want %h", i, got_f, exp_f); end
            pv  = take;
            pmr = take && e.ctrl[8];
            pw  = take ? e.wreg : 5'd0;
        end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rnd_halted got %b want 0", halted); end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_instr = HALT;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL halt_accept got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_instr = rtype(1, 2, 3, 0, 32);
        for (int k = 1; k <= 7; k++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL halt_ready T+%0d got %b want 0", k, in_ready); end
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL halt_valid T+%0d got %b want 0", k, out_valid); end
            n_cmp++; if (halted !== (k >= DRAIN + 1)) begin n_err++; $display("FAIL halt_flag T+%0d got %b want %b", k, halted, k >= DRAIN + 1); end
            @(posedge clk); #1;
        end
        // reset in the middle of a drain must return to RUN
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_instr = HALT;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0;
        #1;
        n_cmp++; if (halted !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL drain_reset got halted=%b ready=%b want 0/1", halted, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DRAIN + 2) @(posedge clk);
        #1;
        n_cmp++; if (halted !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL drain_reset_after got halted=%b ready=%b want 0/1", halted, in_ready); end
    endtask

    task automatic test_halt_flush();
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_instr = HALT;
        @(posedge clk); #1;
        in_valid = 1'b0; in_instr = '0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hf_drain_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hf_flush_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hf_valid got %b want 0", out_valid); end
        repeat (DRAIN + 3) @(posedge clk);
        #1;
        n_cmp++; if (halted !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL hf_run got halted=%b ready=%b want 0/1", halted, in_ready); end
        in_valid = 1'b1; in_instr = rtype(1, 2, 3, 0, 32);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_wreg !== 5'd3) begin n_err++; $display("FAIL hf_issue got %b/%0d want 1/3", out_valid, out_wreg); end
    endtask

    task automatic test_illegal();
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_instr = {6'b111000, 26'h0};
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        n_cmp++; if (illegal !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL ill_trap got illegal=%b valid=%b want 1/0", illegal, out_valid); end
        repeat (DRAIN) @(posedge clk);
        #1;
        n_cmp++; if (halted !== 1'b1 || illegal !== 1'b1) begin n_err++; $display("FAIL ill_halt got halted=%b illegal=%b want 1/1", halted, illegal); end
`else
        n_cmp++; if (out_valid !== 1'b1 || out_ctrl !== 16'h0 || illegal !== 1'b0) begin n_err++; $display("FAIL ill_nop got valid=%b ctrl=%h illegal=%b want 1/0000/0", out_valid, out_ctrl, illegal); end
        repeat (DRAIN + 1) @(posedge clk);
        #1;
        n_cmp++; if (halted !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL ill_run got halted=%b ready=%b want 0/1", halted, in_ready); end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_jal();
        test_flush_stall();
        test_random();
        test_halt();
        test_halt_flush();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
